// File: rtl/prng256_pkg.sv
// Shared constants and types for the 256-bit PRNG output buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prng256_pkg;

    localparam int HALF_W        = 128;
    localparam int WORD_W        = 256;
    localparam int DEPTH_DEF     = 4;
    localparam int REP_LIMIT_DEF = 3;

    // Health-test state: RUN samples normally, FAIL is sticky until reset.
    typedef enum logic {
        RUN  = 1'b0,
        FAIL = 1'b1
    } health_state_t;

endpackage

// File: rtl/prng_rep_test.sv
// Repetition-count health test over consecutive 256-bit samples.
// Latency: trip is combinational on the sampling edge; fail registers one cycle later.
// Backpressure: none; every en=1 cycle in RUN is evaluated, FAIL ignores all input.
// Ports: clk/rst (async active-low), sample + en in, trip (this sample trips), fail (sticky).
module prng_rep_test
    import prng256_pkg::*;
#(
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] sample,
    input  logic              en,
    output logic              trip,
    output logic              fail
);

    localparam int CNT_W = $clog2(REP_LIMIT + 1);

    health_state_t     state;
    logic [WORD_W-1:0] prev;
    logic              prev_vld;
    logic [CNT_W-1:0]  rep_cnt;
    logic              same;
    logic [CNT_W-1:0]  cnt_inc;

    // prev_vld gates the compare so the first sample after reset never matches.
    assign same    = prev_vld && (sample == prev);
    assign cnt_inc = rep_cnt + 1'b1;
    assign trip    = en && (state == RUN) && same && (cnt_inc == CNT_W'(REP_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            fail     <= 1'b0;
            prev     <= '0;
            prev_vld <= 1'b0;
            rep_cnt  <= '0;
        end else if (en && (state == RUN)) begin
            prev     <= sample;
            prev_vld <= 1'b1;
            rep_cnt  <= same ? cnt_inc : CNT_W'(1);
            if (trip) begin
                state <= FAIL;
                fail  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng256_out_buf.sv
// Buffers {rand_b, rand_a} samples in a first-word-fall-through FIFO behind a repetition health test.
// Latency: a push into an empty FIFO is visible on rd_data/rd_valid right after the pushing edge.
// Backpressure: rd_ready stalls the head; samples arriving when full (and no pop) are dropped and counted.
// Ports: clk/rst (async active-low), en/rand_a/rand_b sample input, rd_valid/rd_ready/rd_data read side,
//        fill_level occupancy, drop_cnt saturating drop counter, health_fail sticky health alarm.
module prng256_out_buf
    import prng256_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [HALF_W-1:0]        rand_a,
    input  logic [HALF_W-1:0]        rand_b,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WORD_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              drop_cnt,
    output logic                     health_fail
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [WORD_W-1:0] sample;
    logic              trip;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;

    prng_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk    (clk),
        .rst    (rst),
        .sample (sample),
        .en     (en),
        .trip   (trip),
        .fail   (health_fail)
    );

    assign sample     = {rand_b, rand_a};
    assign rd_valid   = (fill_level != '0);
    assign full       = (fill_level == FILL_W'(DEPTH));
    assign pop        = rd_valid && rd_ready;
    // A tripping sample is neither stored nor counted as a drop.
    assign accept     = en && !health_fail && !trip;
    assign push       = accept && (!full || pop);
    assign drop       = accept && full && !pop;
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    // Storage needs no reset: rd_data comes from its own reset head register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            drop_cnt   <= '0;
            rd_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            // Head register: the next entry is already in mem when more than one is held;
            // otherwise the incoming sample becomes the head. Empty with no push holds last value.
            if (pop) begin
                if (fill_level > FILL_W'(1)) begin
                    rd_data <= mem[rd_ptr_nxt];
                end else if (push) begin
                    rd_data <= sample;
                end
            end else if (push && (fill_level == '0)) begin
                rd_data <= sample;
            end
        end
    end

endmodule

// File: tb/tb_prng256_out_buf.sv
// Directed bench for prng256_out_buf with a queue scoreboard for data order.
// Latency: n/a.
// Backpressure: n/a.
module tb_prng256_out_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] rand_a;
    logic [127:0] rand_b;
    logic         rd_ready;
    logic         rd_valid;
    logic [255:0] rd_data;
    logic [2:0]   fill_level;
    logic [15:0]  drop_cnt;
    logic         health_fail;

    int n_chk  = 0;
    int n_pass = 0;
    logic [255:0] q[$];
    logic [255:0] a_s;
    logic [255:0] b_s;
    logic [255:0] c_s;

    always #5 clk = ~clk;

    prng256_out_buf #(
        .DEPTH     (4),
        .REP_LIMIT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rand_a      (rand_a),
        .rand_b      (rand_b),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fill_level  (fill_level),
        .drop_cnt    (drop_cnt),
        .health_fail (health_fail)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [255:0] smp(input int i);
        return {128'(i + 1000), 128'(i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_smp(input logic [255:0] s, input logic rdy);
        rand_a   = s[127:0];
        rand_b   = s[255:128];
        en       = 1'b1;
        rd_ready = rdy;
        step();
        en       = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [255:0] expv;
        expv = (q.size() > 0) ? q.pop_front() : '0;
        check({tag, "_vld"}, 256'(rd_valid), 256'(1));
        check({tag, "_dat"}, rd_data, expv);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; rd_ready = 1'b0; rand_a = '0; rand_b = '0;
        #2;
        check("rst_vld",    256'(rd_valid),    256'(0));
        check("rst_fill",   256'(fill_level),  256'(0));
        check("rst_drop",   256'(drop_cnt),    256'(0));
        check("rst_health", 256'(health_fail), 256'(0));
        check("rst_data",   rd_data,           256'(0));
        @(negedge clk);
        rst = 1'b1;

        // Single push then pop; empty FIFO with rd_ready holds last data.
        push_smp({128'h2, 128'h1}, 1'b0);
        check("pp_vld",  256'(rd_valid),   256'(1));
        check("pp_dat",  rd_data,          {128'h2, 128'h1});
        check("pp_fill", 256'(fill_level), 256'(1));
        rd_ready = 1'b1;
        step();
        check("pp_vld0", 256'(rd_valid), 256'(0));
        step();
        rd_ready = 1'b0;
        check("empty_fill", 256'(fill_level), 256'(0));
        check("empty_hold", rd_data, {128'h2, 128'h1});

        // Overflow: six samples into four slots.
        for (int i = 1; i <= 6; i++) begin
            push_smp(smp(i), 1'b0);
            if (i <= 4) q.push_back(smp(i));
        end
        check("ovf_fill", 256'(fill_level), 256'(4));
        check("ovf_drop", 256'(drop_cnt),   256'(2));
        for (int i = 0; i < 4; i++) pop_chk("ovf_pop");
        check("ovf_empty", 256'(rd_valid), 256'(0));

        // Reset clears the drop counter.
        #1 rst = 1'b0;
        #1 check("rst2_drop", 256'(drop_cnt), 256'(0));
        rst = 1'b1;

        // Full with simultaneous push and pop across pointer wrap.
        for (int i = 11; i <= 14; i++) begin
            push_smp(smp(i), 1'b0);
            q.push_back(smp(i));
        end
        for (int i = 15; i <= 24; i++) begin
            check("wrap_head", rd_data, q.pop_front());
            q.push_back(smp(i));
            rand_a = smp(i)[127:0];
            rand_b = smp(i)[255:128];
            en = 1'b1;
            rd_ready = 1'b1;
            step();
            check("wrap_fill", 256'(fill_level), 256'(4));
        end
        en = 1'b0; rd_ready = 1'b0;
        check("wrap_drop", 256'(drop_cnt), 256'(0));
        for (int i = 0; i < 4; i++) pop_chk("wrap_drain");

        // Health trip: A, B, C, C stored; third C trips.
        a_s = smp(50); b_s = smp(51); c_s = smp(52);
        push_smp(a_s, 1'b0); q.push_back(a_s);
        push_smp(b_s, 1'b0); q.push_back(b_s);
        push_smp(c_s, 1'b0); q.push_back(c_s);
        push_smp(c_s, 1'b0); q.push_back(c_s);
        check("hp_pre", 256'(health_fail), 256'(0));
        push_smp(c_s, 1'b0);
        check("hp_fail", 256'(health_fail), 256'(1));
        check("hp_fill", 256'(fill_level),  256'(4));
        check("hp_drop", 256'(drop_cnt),    256'(0));
        for (int k = 0; k < 3; k++) push_smp(smp(60 + k), 1'b0);
        check("hf_fill", 256'(fill_level), 256'(4));
        check("hf_drop", 256'(drop_cnt),   256'(0));
        pop_chk("hf_drain");
        check("hf_fill3", 256'(fill_level),  256'(3));
        check("hf_stick", 256'(health_fail), 256'(1));
        check("hf_next",  rd_data,           b_s);

        // Asynchronous reset between edges with fill_level=3 and health_fail=1.
        #2 rst = 1'b0;
        #1;
        check("amr_vld",    256'(rd_valid),    256'(0));
        check("amr_fill",   256'(fill_level),  256'(0));
        check("amr_health", 256'(health_fail), 256'(0));
        check("amr_data",   rd_data,           256'(0));
        q.delete();
        rst = 1'b1;
        push_smp(smp(70), 1'b0);
        check("amr_push_vld", 256'(rd_valid), 256'(1));
        check("amr_push_dat", rd_data,        smp(70));
        q.push_back(smp(70));
        pop_chk("amr_pop");

        // Non-trip pattern A, A, B, A, A; last push coincides with a pop at full.
        a_s = smp(80); b_s = smp(81);
        push_smp(a_s, 1'b0); q.push_back(a_s);
        push_smp(a_s, 1'b0); q.push_back(a_s);
        push_smp(b_s, 1'b0); q.push_back(b_s);
        push_smp(a_s, 1'b0); q.push_back(a_s);
        check("nt_head", rd_data, q.pop_front());
        q.push_back(a_s);
        push_smp(a_s, 1'b1);
        check("nt_fill",   256'(fill_level),  256'(4));
        check("nt_health", 256'(health_fail), 256'(0));
        check("nt_drop",   256'(drop_cnt),    256'(0));
        for (int i = 0; i < 4; i++) pop_chk("nt_drain");
        check("nt_empty", 256'(rd_valid), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prng256_out_buf.md
PRNG256_OUT_BUF -- requirements
Module: prng256_out_buf

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (0 = reset asserted).
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- REP_LIMIT, 3, number of consecutive identical samples that trips the health test; at least 2.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-low reset.
- en, in, 1, sample the generator outputs this cycle.
- rand_a, in, 128, output of PCG instance 1.
- rand_b, in, 128, output of PCG instance 2.
- rd_ready, in, 1, consumer accepts the head word.
- rd_valid, out, 1, head word is available.
- rd_data, out, 256, head word.
- fill_level, out, $clog2(DEPTH)+1, number of entries occupied.
- drop_cnt, out, 16, count of dropped samples.
- health_fail, out, 1, sticky repetition-test failure.

Function
REQ-004 A sample SHALL be the 256-bit word {rand_b, rand_a}, captured on a rising clk edge when en=1.
REQ-005 Push rule: a sample SHALL be written when en=1, health_fail=0, the sample does not trip the health test, and either (fill_level<DEPTH) or (a pop occurs in the same cycle).
REQ-006 Pop rule: a pop SHALL occur on an edge where rd_valid=1 and rd_ready=1.
REQ-007 The FIFO SHALL be first-word fall-through:
- rd_valid = (fill_level != 0).
- rd_data = oldest entry, driven from registers with no combinational path from the inputs.

REQ-008 Latency: a sample pushed into an empty FIFO at edge k SHALL appear on rd_data with rd_valid=1 immediately after edge k.
REQ-009 Simultaneous push and pop SHALL leave fill_level unchanged. This SHALL apply when full and when fill_level=1. Data order SHALL be preserved.
REQ-010 Empty FIFO with rd_ready=1 and no push: no pop; fill_level stays 0; rd_data holds its last value.
REQ-011 Overflow: en=1, health_fail=0, fill_level=DEPTH and no pop means the sample SHALL be dropped and drop_cnt incremented. drop_cnt SHALL saturate at 16'hFFFF.
REQ-012 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-013 Health test (repetition count): on each en=1 edge while health_fail=0, the sample SHALL be compared with the previous sample.
- Equal: rep_cnt increments.
- Different: rep_cnt reloads to 1.
- The first sample after reset: rep_cnt loads 1.

REQ-014 Health test state machine, states RUN and FAIL:
- RUN -> FAIL when the incremented rep_cnt would equal REP_LIMIT.
- FAIL SHALL be left only by reset.
- health_fail = (state == FAIL), asserted the cycle after the tripping edge.

REQ-015 The sample that trips the test SHALL NOT be pushed and SHALL NOT count as a drop.
REQ-016 In FAIL:
- All samples SHALL be ignored: no push, no drop_cnt change, no rep_cnt change.
- Entries already stored SHALL remain poppable.

REQ-017 en=0 SHALL leave rep_cnt and the stored previous sample unchanged; pops still proceed.

Reset
REQ-018 While rst=0 (asynchronously), the block SHALL set:
- rd_valid=0, fill_level=0, drop_cnt=0, health_fail=0, rd_data=0.
- Pointers = 0, rep_cnt = 0, previous-sample-valid = 0, state = RUN.

REQ-019 Reset mid-operation SHALL discard all FIFO contents. The first en=1 edge after release SHALL be treated as the first sample.
REQ-020 The FIFO storage array SHALL NOT require reset. rd_data SHALL read 0 until the first push after reset.

Structure
REQ-021 A shared package prng256_pkg SHALL hold:
- HALF_W=128, WORD_W=256.
- Defaults for DEPTH and REP_LIMIT.
- The health state enumeration {RUN, FAIL}.

REQ-022 The repetition test SHALL be a sub-module prng_rep_test (inputs: sample, en; outputs: trip, fail). The FIFO SHALL stay inline.

Verification
REQ-023 Push then pop: with fill_level=0, apply en=1 for one cycle with rand_a=128'h1, rand_b=128'h2.
- Next cycle: rd_valid=1, rd_data={128'h2,128'h1}, fill_level=1.
- After rd_ready=1 for one edge: rd_valid=0.

REQ-024 Overflow: with rd_ready=0, push 6 distinct samples (DEPTH=4).
- fill_level=4, drop_cnt=2.
- Pops return samples 1..4 in order.

REQ-025 Full with simultaneous push and pop: with fill_level=4, apply en=1 and rd_ready=1 for 10 cycles.
- fill_level stays 4, drop_cnt=0.
- Output order is strictly FIFO across pointer wrap.

REQ-026 Health test trip: apply 3 consecutive identical samples (REP_LIMIT=3).
- First two are pushed; the third is not pushed.
- health_fail=1 the next cycle.
- Further en=1 changes neither fill_level nor drop_cnt.
- Stored entries still drain.

REQ-027 Health test non-trip: samples A,A,B,A,A leave health_fail=0 and push all 5 samples.
REQ-028 Reset mid-stream: with fill_level=3 and health_fail=1, pulse rst=0 asynchronously between edges.
- Outputs immediately read 0 / RUN values.
- After release, the next sample is pushed and rd_valid=1 one cycle later.
